// File: rtl/spi_avalon_bridge.sv
// rtl/spi_avalon_bridge.sv - Avalon-MM slave feeding 32-bit words to an SPI byte-serialiser core
// TX/RX word FIFOs, a four-state launch/capture engine and a registered receive interrupt.
module spi_avalon_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        go_transfer,
    output logic [31:0] core_wdata,
    input  logic [31:0] core_rdata,
    input  logic        data_pack_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DONE,
        ST_CAPTURE,
        ST_WAIT_LOW
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      tx_mem_q [FIFO_DEPTH];
    logic [31:0]      rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [LVL_W-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;

    logic        enable_q, enable_d;
    logic        irq_en_q, irq_en_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        irq_q, irq_d;
    logic [31:0] avs_readdata_q, avs_readdata_d;
    logic [31:0] core_wdata_q, core_wdata_d;

    logic wr_data, wr_status, wr_ctrl, rd_data, flush;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop, launch;
    logic [31:0] status;

    assign wr_data   = avs_write && (avs_address == 2'd0);
    assign wr_status = avs_write && (avs_address == 2'd1);
    assign wr_ctrl   = avs_write && (avs_address == 2'd2);
    assign rd_data   = avs_read  && (avs_address == 2'd0);
    assign flush     = wr_ctrl && avs_writedata[2];

    assign tx_full  = (tx_lvl_q == FULL_LVL);
    assign tx_empty = (tx_lvl_q == '0);
    assign rx_full  = (rx_lvl_q == FULL_LVL);
    assign rx_empty = (rx_lvl_q == '0);

    // Overflow is judged on the level at the start of the cycle, ignoring a same-cycle pop.
    assign tx_push = wr_data && !tx_full;
    assign tx_pop  = launch;
    assign rx_pop  = rd_data && !rx_empty;

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_q && !tx_empty && !rx_full) begin
                    launch  = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (data_pack_ready) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rx_push = 1'b1;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!data_pack_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The launched word is presented in the launch cycle itself and held afterwards.
    assign core_wdata_d = launch ? tx_mem_q[tx_rd_ptr_q] : core_wdata_q;
    assign core_wdata   = core_wdata_d;
    assign go_transfer  = launch;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(tx_pop);
        tx_lvl_d    = tx_lvl_q + LVL_W'(tx_push) - LVL_W'(tx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(rx_pop);
        rx_lvl_d    = rx_lvl_q + LVL_W'(rx_push) - LVL_W'(rx_pop);
        if (flush) begin
            // A capture landing in the flush cycle survives as the only RX entry.
            tx_rd_ptr_d = tx_wr_ptr_q;
            tx_wr_ptr_d = tx_wr_ptr_q;
            tx_lvl_d    = '0;
            rx_rd_ptr_d = rx_wr_ptr_q;
            rx_lvl_d    = LVL_W'(rx_push);
        end
    end

    always_comb begin
        enable_d = wr_ctrl ? avs_writedata[0] : enable_q;
        irq_en_d = wr_ctrl ? avs_writedata[1] : irq_en_q;
        tx_ovf_d = tx_ovf_q;
        if (wr_data && tx_full) begin
            tx_ovf_d = 1'b1;
        end
        if ((wr_status && avs_writedata[5]) || flush) begin
            tx_ovf_d = 1'b0;
        end
        irq_d = irq_en_d && (rx_lvl_d != '0);
    end

    always_comb begin
        status                = '0;
        status[0]             = (state_q != ST_IDLE);
        status[1]             = tx_full;
        status[2]             = tx_empty;
        status[3]             = rx_empty;
        status[4]             = rx_full;
        status[5]             = tx_ovf_q;
        status[8 +: LVL_W]    = tx_lvl_q;
        status[16 +: LVL_W]   = rx_lvl_q;
    end

    always_comb begin
        avs_readdata_d = avs_readdata_q;
        if (avs_read) begin
            case (avs_address)
                2'd0:    avs_readdata_d = rx_empty ? 32'h0 : rx_mem_q[rx_rd_ptr_q];
                2'd1:    avs_readdata_d = status;
                2'd2:    avs_readdata_d = {30'h0, irq_en_q, enable_q};
                default: avs_readdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= avs_writedata;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= core_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tx_wr_ptr_q    <= '0;
            tx_rd_ptr_q    <= '0;
            tx_lvl_q       <= '0;
            rx_wr_ptr_q    <= '0;
            rx_rd_ptr_q    <= '0;
            rx_lvl_q       <= '0;
            enable_q       <= 1'b0;
            irq_en_q       <= 1'b0;
            tx_ovf_q       <= 1'b0;
            irq_q          <= 1'b0;
            avs_readdata_q <= '0;
            core_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            tx_wr_ptr_q    <= tx_wr_ptr_d;
            tx_rd_ptr_q    <= tx_rd_ptr_d;
            tx_lvl_q       <= tx_lvl_d;
            rx_wr_ptr_q    <= rx_wr_ptr_d;
            rx_rd_ptr_q    <= rx_rd_ptr_d;
            rx_lvl_q       <= rx_lvl_d;
            enable_q       <= enable_d;
            irq_en_q       <= irq_en_d;
            tx_ovf_q       <= tx_ovf_d;
            irq_q          <= irq_d;
            avs_readdata_q <= avs_readdata_d;
            core_wdata_q   <= core_wdata_d;
        end
    end

    assign avs_readdata = avs_readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_spi_avalon_bridge.sv
// tb/tb_spi_avalon_bridge.sv - directed bench for spi_avalon_bridge with a loopback core model
module tb_spi_avalon_bridge;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        irq;
    logic        go_transfer;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        data_pack_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] launches[$];
    logic [31:0] cap;
    bit          core_stall = 1'b0;
    bit          core_busy  = 1'b0;
    int          core_cnt   = 0;
    int          core_lat   = 3;

    spi_avalon_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .irq             (irq),
        .go_transfer     (go_transfer),
        .core_wdata      (core_wdata),
        .core_rdata      (core_rdata),
        .data_pack_ready (data_pack_ready)
    );

    always #5 clk = ~clk;

    // Loopback core: returns the launched word, ready held high for two cycles.
    always @(negedge clk) begin
        if (!reset_n) begin
            core_busy       = 1'b0;
            core_cnt        = 0;
            data_pack_ready = 1'b0;
        end else if (go_transfer) begin
            launches.push_back(core_wdata);
            cap       = core_wdata;
            core_busy = 1'b1;
            core_cnt  = 0;
        end else if (core_busy && !core_stall) begin
            core_cnt++;
            if (core_cnt == core_lat) begin
                core_rdata      = cap;
                data_pack_ready = 1'b1;
            end
            if (core_cnt == core_lat + 2) begin
                data_pack_ready = 1'b0;
                core_busy       = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d        = avs_readdata;
    endtask

    task automatic wait_rx_lvl(input int lvl, input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            avs_rd(2'd1, s);
            n++;
        end while ((32'(s[16 +: LW]) != 32'(lvl)) && (n < 200));
        check(tag, 32'(s[16 +: LW]), 32'(lvl));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] d;
    logic [31:0] burst [5];
    logic [31:0] bp    [5];
    int          n;

    initial begin
        reset_n       = 1'b0;
        avs_address   = 2'd0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        avs_read      = 1'b0;
        core_rdata    = 32'h0;
        data_pack_ready = 1'b0;
        wait_cycles(3);
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_irq", irq, 32'h0);
        check("rst_go", go_transfer, 32'h0);
        check("rst_wdata", core_wdata, 32'h0);
        reset_n = 1'b1;
        avs_rd(2'd1, d);
        check("rst_status", d, 32'h0000_000C);
        avs_rd(2'd2, d);
        check("rst_ctrl", d, 32'h0);
        avs_rd(2'd3, d);
        check("addr3_read", d, 32'h0);
        avs_rd(2'd0, d);
        check("empty_rx_read", d, 32'h0);

        // Single word, exact launch latency.
        avs_wr(2'd2, 32'h1);
        launches.delete();
        @(negedge clk);
        avs_address   = 2'd0;
        avs_writedata = 32'h4433_2211;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        check("single_go_n1", go_transfer, 32'h1);
        check("single_wdata", core_wdata, 32'h4433_2211);
        @(negedge clk);
        check("single_go_pulse", go_transfer, 32'h0);
        check("single_wdata_hold", core_wdata, 32'h4433_2211);
        wait_rx_lvl(1, "single_rx_lvl");
        avs_rd(2'd0, d);
        check("single_rdata", d, 32'h4433_2211);
        avs_rd(2'd1, d);
        check("single_rx_empty", d & 32'h8, 32'h8);
        check("single_launches", launches.size(), 32'd1);

        // IRQ timing relative to the first data_pack_ready cycle.
        avs_wr(2'd2, 32'h3);
        avs_wr(2'd0, 32'hA5A5_0001);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!data_pack_ready && (n < 50));
        check("irq_dpr_seen", data_pack_ready, 32'h1);
        @(negedge clk);
        check("irq_m1_low", irq, 32'h0);
        @(negedge clk);
        check("irq_m2_high", irq, 32'h1);
        wait_cycles(4);
        avs_rd(2'd0, d);
        check("irq_rdata", d, 32'hA5A5_0001);
        @(negedge clk);
        check("irq_fall", irq, 32'h0);

        // Burst with overflow while disabled.
        avs_wr(2'd2, 32'h0);
        for (int i = 0; i < 5; i++) begin
            burst[i] = 32'hB000_0000 + 32'(i * 17);
            avs_wr(2'd0, burst[i]);
        end
        avs_rd(2'd1, d);
        check("burst_status_ovf", d, 32'h0000_042A);
        launches.delete();
        avs_wr(2'd2, 32'h1);
        wait_rx_lvl(4, "burst_rx_lvl");
        wait_cycles(10);
        check("burst_launches", launches.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < launches.size()) begin
                check("burst_order", launches[i], burst[i]);
            end
        end
        avs_rd(2'd1, d);
        check("burst_status_full", d, 32'h0004_0034);
        avs_wr(2'd1, 32'h20);
        avs_rd(2'd1, d);
        check("burst_ovf_clear", d, 32'h0004_0014);
        for (int i = 0; i < 4; i++) begin
            avs_rd(2'd0, d);
            check("burst_rdata", d, burst[i]);
        end

        // RX back-pressure holds the fifth launch until one word is read.
        launches.delete();
        for (int i = 0; i < 5; i++) begin
            bp[i] = 32'hC0DE_0000 | 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            avs_wr(2'd0, bp[i]);
        end
        wait_rx_lvl(4, "bp_rx_full");
        wait_cycles(10);
        avs_wr(2'd0, bp[4]);
        wait_cycles(20);
        check("bp_no_launch", launches.size(), 32'd4);
        avs_rd(2'd1, d);
        check("bp_status", d, 32'h0004_0110);
        avs_rd(2'd0, d);
        check("bp_rdata0", d, bp[0]);
        check("bp_go_after_read", go_transfer, 32'h1);
        check("bp_wdata", core_wdata, bp[4]);
        wait_rx_lvl(4, "bp_rx_refill");
        for (int i = 1; i < 5; i++) begin
            avs_rd(2'd0, d);
            check("bp_rdata", d, bp[i]);
        end

        // Flush during WAIT_DONE keeps the in-flight word.
        launches.delete();
        core_stall = 1'b1;
        avs_wr(2'd0, 32'hF1F1_0000);
        wait_cycles(3);
        avs_wr(2'd0, 32'hF1F1_0001);
        avs_wr(2'd0, 32'hF1F1_0002);
        avs_rd(2'd1, d);
        check("flush_pre_status", d, 32'h0000_0209);
        avs_wr(2'd2, 32'h4);
        avs_rd(2'd1, d);
        check("flush_status", d, 32'h0000_000D);
        avs_rd(2'd2, d);
        check("flush_ctrl_read", d, 32'h0);
        core_stall = 1'b0;
        wait_rx_lvl(1, "flush_rx_lvl");
        avs_rd(2'd0, d);
        check("flush_rdata", d, 32'hF1F1_0000);
        check("flush_launches", launches.size(), 32'd1);

        // Clearing enable mid-packet stops further launches.
        launches.delete();
        avs_wr(2'd2, 32'h1);
        core_stall = 1'b1;
        avs_wr(2'd0, 32'hD0D0_0000);
        wait_cycles(3);
        avs_wr(2'd0, 32'hD0D0_0001);
        avs_wr(2'd2, 32'h0);
        core_stall = 1'b0;
        wait_rx_lvl(1, "dis_rx_lvl");
        wait_cycles(20);
        check("dis_launches", launches.size(), 32'd1);
        avs_rd(2'd1, d);
        check("dis_status", d, 32'h0001_0100);
        avs_rd(2'd0, d);
        check("dis_rdata", d, 32'hD0D0_0000);
        avs_wr(2'd2, 32'h4);
        avs_rd(2'd1, d);
        check("dis_flush_status", d, 32'h0000_000C);

        // Asynchronous reset in WAIT_DONE.
        avs_wr(2'd2, 32'h3);
        avs_wr(2'd0, 32'hEEEE_0000);
        wait_rx_lvl(1, "rst_mid_rx_lvl");
        check("rst_mid_irq_pre", irq, 32'h1);
        core_stall = 1'b1;
        avs_wr(2'd0, 32'hEEEE_0001);
        wait_cycles(3);
        avs_rd(2'd1, d);
        check("rst_mid_busy", d & 32'h1, 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_go", go_transfer, 32'h0);
        check("rst_mid_wdata", core_wdata, 32'h0);
        check("rst_mid_irq", irq, 32'h0);
        check("rst_mid_readdata", avs_readdata, 32'h0);
        @(negedge clk);
        reset_n    = 1'b1;
        core_stall = 1'b0;
        avs_rd(2'd1, d);
        check("rst_mid_status", d, 32'h0000_000C);
        avs_rd(2'd2, d);
        check("rst_mid_ctrl", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_avalon_bridge.md
# spi_avalon_bridge

Avalon-MM register slave that sits directly upstream of the SPI byte-serialiser core. It buffers CPU-written 32-bit words in a TX FIFO and launches one 4-byte SPI packet per word with a single-cycle go_transfer pulse. It captures the 32-bit word received back when the core signals data_pack_ready, queues it in an RX FIFO for the CPU, and raises an interrupt when receive data is available.

## Interface
- FIFO_DEPTH, 4, entries per FIFO; power of two, 2..16
- LVL_W, $clog2(FIFO_DEPTH)+1, FIFO level width
- clk  in  1  system clock, same clock as the SPI core
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  2  word address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, fixed read latency 1
- irq  out  1  interrupt, active high, registered
- go_transfer  out  1  one-cycle packet launch pulse to the core
- core_wdata  out  32  packet word to the core; byte [7:0] is sent first
- core_rdata  in  32  packet word assembled by the core
- data_pack_ready  in  1  core packet-complete indication

## Operation
- Register map (word address):
  - 0 write: push to TX FIFO.
  - 0 read: pop RX FIFO. An empty read returns 0 and does not pop.
  - 1 STATUS, read: bit0 busy (engine not IDLE), bit1 tx_full, bit2 tx_empty, bit3 rx_empty, bit4 rx_full, bit5 tx_ovf (sticky), [8+LVL_W-1:8] tx level, [16+LVL_W-1:16] rx level. Writing 1 to bit5 clears tx_ovf.
  - 2 CONTROL, R/W: bit0 enable, bit1 irq_en. Bit2 is flush: write 1 only, self-clearing, reads 0.
  - 3: reads 0, writes are ignored.
- TX write while tx_full (judged on pre-cycle state, even if the engine pops that cycle): data is dropped and tx_ovf is set.
- Engine FSM:
  - IDLE: when enable && !tx_empty && !rx_full, pop TX, load core_wdata, assert go_transfer for 1 cycle, go to WAIT_DONE.
  - WAIT_DONE: when data_pack_ready==1, go to CAPTURE.
  - CAPTURE: push core_rdata into RX FIFO, go to WAIT_LOW.
  - WAIT_LOW: when data_pack_ready==0, go to IDLE.
- Because launch requires !rx_full, the CAPTURE push never overflows the RX FIFO.
- core_wdata is held stable from launch until the next launch.
- Flush: empties both FIFOs and clears tx_ovf in the cycle after the write. An in-flight transfer is not aborted; its captured word is still pushed to the RX FIFO.
- Clearing enable mid-transfer: the current packet completes and is captured; no new launch follows.
- irq <= irq_en && !rx_empty, registered.
- Simultaneous events:
  - RX pop and CAPTURE push in the same cycle: both take effect, level unchanged.
  - TX push (not full) and engine pop in the same cycle: both take effect.
- FIFO pointers wrap modulo FIFO_DEPTH. Level counts 0..FIFO_DEPTH.
- Reset values: avs_readdata=0, irq=0, go_transfer=0, core_wdata=0. FIFOs are empty, CONTROL=0, tx_ovf=0, FSM is IDLE.
- Reset asserted mid-transfer: all state returns to reset values immediately. The core is reset by the same reset_n.

## Timing
- Read data is valid on avs_readdata in the cycle after avs_read. Status reflects state before that cycle's updates.
- Write-to-launch: a TX write in cycle N with the engine idle and enabled puts go_transfer high in cycle N+1.
- Packet-end-to-RX: first data_pack_ready high in cycle M puts the word in the RX FIFO at the end of M+1; rx_empty reads 0 from M+2; irq is high in M+2.
- Minimum gap between packets: 1 cycle after data_pack_ready falls (WAIT_LOW -> IDLE -> launch).
- avs_waitrequest is not provided; the slave never stalls.

## Test plan
- Single word: enable=1, write 0x44332211 -> one go_transfer pulse, core_wdata=0x44332211; after the core loopback, reading addr 0 returns 0x44332211 and STATUS.rx_empty=1.
- Burst: enable=0, write 5 words with FIFO_DEPTH=4 -> 4 accepted, tx_ovf=1, tx level=4. Then enable=1 -> exactly 4 packets in write order, rx level=4; writing 0x20 to STATUS clears tx_ovf.
- RX back-pressure: 4 packets fill RX with a 5th word in TX -> no launch while rx_full. One RX read -> 5th packet launches within 2 cycles.
- IRQ: irq_en=1, one packet completes -> irq rises 1 cycle after rx becomes non-empty; reading the word -> irq falls the cycle after rx_empty.
- Flush/enable mid-transfer: during WAIT_DONE, write CONTROL=0x4 -> TX emptied and the in-flight word is still captured (rx level=1). Clear enable during a packet -> no further go_transfer.
- Reset mid-packet: assert reset_n=0 in WAIT_DONE -> go_transfer=0, core_wdata=0, irq=0, STATUS=0x0C (tx_empty, rx_empty).
